// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a word-wide big-endian data memory.
// Performs read-modify-write for sub-word stores and an atomic RD/WR pair for swaps.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  output logic              mem_we_o,
  input  logic [31:0]       mem_dout_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_data_o,
  output logic              resp_err_o,
  output logic [TAG_W-1:0]  resp_tag_o
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q;
  logic [1:0]          op_q, size_q, off_q;
  logic                sgn_q;
  logic [31:0]         wdata_q, rbuf_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_din_q, resp_data_q;
  logic                mem_we_q, resp_valid_q, resp_err_q;
  logic [TAG_W-1:0]    resp_tag_q;
  logic [31:0]         ld_data_d, wr_data_d;

  function automatic logic req_is_err(input logic [1:0] op, input logic [1:0] size,
                                      input logic [1:0] off);
    return (op == 2'b11) || (size == 2'b11) || (op == OP_SWAP && size != SZ_WORD) ||
           (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction

  // Big-endian lanes: offset 0 is the most significant byte.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[15:0]  = d[15:0];
        else        r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign ld_data_d = load_extract(mem_dout_i, size_q, off_q, sgn_q);
  assign wr_data_d = (op_q == OP_SWAP) ? wdata_q : store_merge(mem_dout_i, wdata_q, size_q, off_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      sgn_q        <= 1'b0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_q        <= req_op_i;
            size_q      <= req_size_i;
            off_q       <= req_addr_i[1:0];
            sgn_q       <= req_signed_i;
            wdata_q     <= req_wdata_i;
            resp_tag_q  <= req_tag_i;
            resp_data_q <= '0;
            if (req_is_err(req_op_i, req_size_i, req_addr_i[1:0])) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              resp_err_q <= 1'b0;
              mem_addr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
              // Full-word stores need no read; go straight to the write cycle.
              if (req_op_i == OP_STORE && req_size_i == SZ_WORD) begin
                mem_din_q <= req_wdata_i;
                mem_we_q  <= 1'b1;
                state_q   <= WR;
              end else begin
                state_q <= RD;
              end
            end
          end
        end
        RD: begin
          rbuf_q <= mem_dout_i;
          if (op_q == OP_LOAD) begin
            resp_data_q  <= ld_data_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            mem_din_q <= wr_data_d;
            mem_we_q  <= 1'b1;
            state_q   <= WR;
          end
        end
        WR: begin
          mem_we_q     <= 1'b0;
          resp_data_q  <= (op_q == OP_SWAP) ? rbuf_q : 32'd0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign mem_addr_o   = mem_addr_q;
  assign mem_din_o    = mem_din_q;
  assign mem_we_o     = mem_we_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign resp_tag_o   = resp_tag_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small big-endian word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_tag = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [4:0]  resp_tag;

  int vectors = 0;
  int miscompares = 0;
  int we_count = 0;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  load_store_unit #(.ADDR_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_tag_i(req_tag),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_we_o(mem_we), .mem_dout_i(mem_dout),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .resp_tag_o(resp_tag)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_din;
      we_count <= we_count + 1;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running required done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_idx  = addr[9:2];
    pl_data = data;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] tag);
    req_op = op; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_tag = tag;
    req_valid = 1'b1;
  endtask

  // Issue one request, measure latency from the acceptance edge, check the response.
  task automatic do_req(input string name, input logic [1:0] op, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] tag, input int exp_lat, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_writes);
    int lat;
    int w0;
    w0 = we_count;
    chk({name, ".ready"}, 32'(req_ready), 32'd1);
    drive(op, size, sgn, addr, wdata, tag);
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      step();
      lat++;
    end
    chk({name, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({name, ".data"}, resp_data, exp_data);
    chk({name, ".err"}, 32'(resp_err), 32'(exp_err));
    chk({name, ".tag"}, 32'(resp_tag), 32'(tag));
    step();
    chk({name, ".vld_drop"}, 32'(resp_valid), 32'd0);
    chk({name, ".writes"}, 32'(we_count - w0), 32'(exp_writes));
  endtask

  initial begin
    int seen;
    // Reset state
    #12;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.din", mem_din, 32'd0);
    chk("rst.vld", 32'(resp_valid), 32'd0);
    chk("rst.data", resp_data, 32'd0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.tag", 32'(resp_tag), 32'd0);
    rst = 1'b0;
    step();
    chk("rst.ready_after", 32'(req_ready), 32'd1);

    // Loads with extension
    preload(32'h100, 32'h80FF7F01);
    do_req("lb_s",  2'b00, 2'b00, 1'b1, 32'h101, 32'h0, 5'h01, 2, 32'hFFFFFFFF, 1'b0, 0);
    do_req("lb_u",  2'b00, 2'b00, 1'b0, 32'h101, 32'h0, 5'h02, 2, 32'h000000FF, 1'b0, 0);
    do_req("lh_s",  2'b00, 2'b01, 1'b1, 32'h100, 32'h0, 5'h03, 2, 32'hFFFF80FF, 1'b0, 0);
    do_req("lh_u",  2'b00, 2'b01, 1'b0, 32'h102, 32'h0, 5'h04, 2, 32'h00007F01, 1'b0, 0);
    do_req("lw",    2'b00, 2'b10, 1'b0, 32'h100, 32'h0, 5'h05, 2, 32'h80FF7F01, 1'b0, 0);
    do_req("lb_s3", 2'b00, 2'b00, 1'b1, 32'h103, 32'h0, 5'h06, 2, 32'h00000001, 1'b0, 0);

    // Byte store read-modify-write, cycle by cycle
    preload(32'h100, 32'h11223344);
    drive(2'b01, 2'b00, 1'b0, 32'h102, 32'h000000AB, 5'h0A);
    step();
    req_valid = 1'b0;
    chk("sb.t1_we", 32'(mem_we), 32'd0);
    chk("sb.t1_addr", mem_addr, 32'h100);
    step();
    chk("sb.t2_we", 32'(mem_we), 32'd1);
    chk("sb.t2_din", mem_din, 32'h1122AB44);
    chk("sb.t2_vld", 32'(resp_valid), 32'd0);
    step();
    chk("sb.t3_we", 32'(mem_we), 32'd0);
    chk("sb.t3_vld", 32'(resp_valid), 32'd1);
    chk("sb.t3_data", resp_data, 32'd0);
    chk("sb.t3_tag", 32'(resp_tag), 32'h0A);
    step();
    do_req("sb_reread", 2'b00, 2'b10, 1'b0, 32'h100, 32'h0, 5'h0B, 2, 32'h1122AB44, 1'b0, 0);

    // Half store and word store
    do_req("sh_lo", 2'b01, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 5'h0C, 3, 32'd0, 1'b0, 1);
    chk("sh_lo.mem", mem[8'h40], 32'h1122BEEF);
    do_req("sw", 2'b01, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D, 5'h0D, 2, 32'd0, 1'b0, 1);
    chk("sw.mem", mem[8'h41], 32'hCAFEF00D);

    // Misaligned and reserved requests
    do_req("sh_mis", 2'b01, 2'b01, 1'b0, 32'h101, 32'h1234, 5'h11, 1, 32'd0, 1'b1, 0);
    do_req("lw_mis", 2'b00, 2'b10, 1'b0, 32'h102, 32'h0, 5'h12, 1, 32'd0, 1'b1, 0);
    do_req("op_rsv", 2'b11, 2'b10, 1'b0, 32'h100, 32'h0, 5'h13, 1, 32'd0, 1'b1, 0);
    do_req("swp_b",  2'b10, 2'b00, 1'b0, 32'h100, 32'h0, 5'h14, 1, 32'd0, 1'b1, 0);
    chk("err.mem", mem[8'h40], 32'h1122BEEF);

    // Atomic swap
    preload(32'h100, 32'h11223344);
    do_req("swap", 2'b10, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'h15, 3, 32'h11223344, 1'b0, 1);
    do_req("swap_rd", 2'b00, 2'b10, 1'b0, 32'h100, 32'h0, 5'h16, 2, 32'hDEADBEEF, 1'b0, 0);

    // Response backpressure
    resp_ready = 1'b0;
    drive(2'b00, 2'b10, 1'b0, 32'h100, 32'h0, 5'h07);
    step();
    req_valid = 1'b0;
    step();
    chk("bp.vld", 32'(resp_valid), 32'd1);
    drive(2'b00, 2'b00, 1'b1, 32'h100, 32'h0, 5'h09);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.hold_vld", 32'(resp_valid), 32'd1);
      chk("bp.hold_data", resp_data, 32'hDEADBEEF);
      chk("bp.hold_tag", 32'(resp_tag), 32'h07);
      chk("bp.hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("bp.hs_vld", 32'(resp_valid), 32'd0);
    chk("bp.hs_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("bp.accept", 32'(req_ready), 32'd0);
    chk("bp.t1_vld", 32'(resp_valid), 32'd0);
    step();
    chk("bp.t2_vld", 32'(resp_valid), 32'd1);
    chk("bp.t2_data", resp_data, 32'hFFFFFFDE);
    chk("bp.t2_tag", 32'(resp_tag), 32'h09);
    step();

    // Reset in the write cycle of a byte store
    preload(32'h100, 32'h11223344);
    drive(2'b01, 2'b00, 1'b0, 32'h103, 32'h00000055, 5'h1E);
    step();
    req_valid = 1'b0;
    step();
    chk("ar.we_before", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.we_async", 32'(mem_we), 32'd0);
    chk("ar.addr", mem_addr, 32'd0);
    chk("ar.din", mem_din, 32'd0);
    chk("ar.ready", 32'(req_ready), 32'd0);
    chk("ar.vld", 32'(resp_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (resp_valid) seen++;
    end
    chk("ar.no_resp", 32'(seen), 32'd0);
    chk("ar.mem", mem[8'h40], 32'h11223344);
    do_req("ar.lw", 2'b00, 2'b10, 1'b0, 32'h100, 32'h0, 5'h1F, 2, 32'h11223344, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequencing stage between the execute stage and the data memory. It accepts one memory request per handshake: load, store, or atomic swap, at byte, half or word size. It drives the data memory's word-wide big-endian port with aligned word addresses and performs read-modify-write for sub-word stores. It returns sign- or zero-extended load data, or the old word for a swap, through a valid/ready response channel.

Parameters:
ADDR_W, 32, byte address width.
TAG_W, 5, width of the destination tag echoed from request to response.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE and rst low.
req_op  input  2  00 load, 01 store, 10 swap, 11 reserved.
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
req_signed  input  1  loads only: 1 sign-extends, 0 zero-extends.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store/swap data, right-justified for sub-word stores.
req_tag  input  TAG_W  echoed on the response.
mem_addr  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}.
mem_din  output  32  word written to memory.
mem_we  output  1  write strobe.
mem_dout  input  32  combinational big-endian read of mem_addr..mem_addr+3.
resp_valid  output  1  response present.
resp_ready  input  1  consumer accepts the response.
resp_data  output  32  load result, or old word for a swap; 0 for stores and errors.
resp_err  output  1  misaligned or reserved request.
resp_tag  output  TAG_W  tag of the request.

Behaviour:
- Reset (async, immediate): state=IDLE.
  - mem_we=0, mem_addr=0, mem_din=0.
  - resp_valid=0, resp_err=0, resp_data=0, resp_tag=0, req_ready=0 while rst high.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: on req_valid&&req_ready, latch op, size, signed, addr, wdata and tag. Next state:
  - Error if op=11, size=11, swap with size≠word, half with addr[0]≠0, or word with addr[1:0]≠0 -> RESP with resp_err=1. No memory access.
  - Load, sub-word store or swap -> RD.
  - Word store -> WR.
- RD (1 cycle): mem_addr driven, mem_we=0. Capture mem_dout into rbuf at the edge.
  - Load -> RESP.
  - Store or swap -> WR.
- WR (exactly 1 cycle): mem_we=1, mem_addr held.
  - Word store or swap: mem_din=wdata.
  - Half store: mem_din=rbuf with lane replaced by wdata[15:0].
  - Byte store: mem_din=rbuf with lane replaced by wdata[7:0].
  - Next state -> RESP.
- Byte lanes are big-endian. Byte offset k=addr[1:0] selects bits [31-8k:24-8k]. Half offset 0 selects [31:16]; offset 2 selects [15:0].
- Load extraction: the selected lane is right-justified, then extended per req_signed. Word loads are returned unchanged.
- RESP: resp_valid=1. resp_data, resp_err and resp_tag are held stable until resp_ready. On resp_valid&&resp_ready -> IDLE, and resp_valid drops next cycle.
- Latency from acceptance edge T: resp_valid asserts at
  - T+1 for errors
  - T+2 for loads and word stores
  - T+3 for sub-word stores and swaps.
- No overlap: req_ready=0 outside IDLE. The next request can be accepted one cycle after the response handshake.
- Swap is atomic by construction: no other request can reach memory between its RD and WR.
- mem_we is asserted only in WR, for exactly one cycle per request. It is never asserted for loads or errors.
- Reset during RD or WR: mem_we drops asynchronously, the pending request is discarded, and no response is produced.
- Address wrap: only low bits are masked, so 0xFFFFFFFC is a legal word address.

Test Plan:
1. Memory word 0x100=0x80FF7F01, loads:
   - LB signed 0x101 -> resp_data 0xFFFFFFFF.
   - LB unsigned 0x101 -> 0x000000FF.
   - LH signed 0x100 -> 0xFFFF80FF.
   - LH unsigned 0x102 -> 0x00007F01.
   - LW 0x100 -> 0x80FF7F01.
   - Each resp_valid at T+2.
2. Word 0x100=0x11223344, SB wdata 0x000000AB at 0x102 -> mem_we high only at T+2 with mem_din 0x1122AB44; resp_valid at T+3 with resp_data 0; reread gives 0x1122AB44.
3. SH at 0x101 and LW at 0x102 -> resp_err=1 at T+1, mem_we never asserts, memory unchanged, resp_tag matches request.
4. Word 0x100=0x11223344, SWAP wdata 0xDEADBEEF -> resp_data 0x11223344 at T+3; subsequent LW returns 0xDEADBEEF.
5. Load with resp_ready held low 3 cycles -> resp_valid, resp_data and resp_tag stable, req_ready=0, and a pending req_valid is not accepted. Release resp_ready -> next request accepted one cycle after the handshake.
6. Assert rst during WR of an SB -> mem_we falls without waiting for a clock edge; after reset all outputs are at reset values and no resp_valid appears for the aborted request.
